serial_subtractor: RTL

//   Parametrised bit-serial WIDTH-bit subtractor: diff = a - b - bin, one bit per clock, LSB first.

---
 rtl/serial_subtractor.sv | 138 +++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// ============================================================================
// serial_subtractor : bit-serial WIDTH-bit a - b - bin, LSB first, with a
// start/busy/done handshake. Optional macro SUB_SIGNED_OVF_EN adds ovf.
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SUB_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    generate
        if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
            $error("serial_subtractor: WIDTH must be in 2..64");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_sr_q;
    logic [WIDTH-1:0]   b_sr_q;
    logic               borrow_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   diff_q;
    logic               bout_q;
`ifdef SUB_SIGNED_OVF_EN
    logic               ovf_q;
`endif

    // Full-subtractor cell on the current LSBs and the running borrow.
    logic               x_bit;
    logic               y_bit;
    logic               diff_bit_d;
    logic               borrow_d;
    logic [WIDTH-1:0]   result_d;

    assign x_bit      = a_sr_q[0];
    assign y_bit      = b_sr_q[0];
    assign diff_bit_d = x_bit ^ y_bit ^ borrow_q;
    assign borrow_d   = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & borrow_q);

    // The minuend register doubles as the result accumulator: each consumed
    // bit frees the MSB slot that receives the new difference bit.
    assign result_d   = {diff_bit_d, a_sr_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_sr_q   <= a;
                        b_sr_q   <= b;
                        borrow_q <= bin;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_sr_q   <= result_d;
                    b_sr_q   <= b_sr_q >> 1;
                    borrow_q <= borrow_d;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        diff_q  <= result_d;
                        bout_q  <= borrow_d;
`ifdef SUB_SIGNED_OVF_EN
                        // borrow_q here is the borrow into the MSB.
                        ovf_q   <= borrow_q ^ borrow_d;
`endif
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
`ifdef SUB_SIGNED_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

`default_nettype wire
